// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, debounce and latch button presses as move requests with left/right auto-repeat
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rotate,
  input  logic enable,
  input  logic consume,
  output logic left,
  output logic right,
  output logic rotate,
  output logic any_pending
);
  logic [2:0] raw, ev;
  assign raw = {btn_rotate, btn_right, btn_left};
  genvar i;
  generate
    for (i = 0; i < 3; i++) begin : g_btn
      logic s1, s2, stable, stable_q, press;
      logic [CNT_W-1:0] db_cnt;
      always_ff @(posedge clk)
        if (!reset_n) begin
          s1       <= 1'b0;
          s2       <= 1'b0;
          stable   <= 1'b0;
          stable_q <= 1'b0;
          db_cnt   <= '0;
        end else begin
          s1       <= raw[i];
          s2       <= s1;
          stable_q <= stable;
          if (s2 == stable) db_cnt <= '0;
          else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
            db_cnt <= '0;
          end else db_cnt <= db_cnt + 1'b1;
        end
      assign press = stable & ~stable_q;
      if (i < 2) begin : g_rep
        typedef enum logic {IDLE, HELD} state_t;
        state_t state, state_n;
        logic phase, phase_n, rep;
        logic [CNT_W-1:0] rcnt, rcnt_n;
        always_ff @(posedge clk)
          if (!reset_n) begin
            state <= IDLE;
            phase <= 1'b0;
            rcnt  <= '0;
          end else begin
            state <= state_n;
            phase <= phase_n;
            rcnt  <= rcnt_n;
          end
        // phase 0 waits for the initial delay, phase 1 for each further period
        always_comb begin
          state_n = state;
          phase_n = phase;
          rcnt_n  = rcnt + 1'b1;
          rep     = 1'b0;
          if (!enable || !stable || state == IDLE) begin
            state_n = (enable && press) ? HELD : IDLE;
            phase_n = 1'b0;
            rcnt_n  = '0;
          end else if (rcnt == (phase ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1))) begin
            rep     = 1'b1;
            phase_n = 1'b1;
            rcnt_n  = '0;
          end
        end
        assign ev[i] = press | rep;
      end else begin : g_norep
        assign ev[i] = press;
      end
    end
  endgenerate
  // a new event always beats consume; simultaneous left+right cancel each other
  always_ff @(posedge clk)
    if (!reset_n || !enable) begin
      left   <= 1'b0;
      right  <= 1'b0;
      rotate <= 1'b0;
    end else begin
      left   <= ev[0] ? ~ev[1] : ~ev[1] & ~consume & left;
      right  <= ev[1] ? ~ev[0] : ~ev[0] & ~consume & right;
      rotate <= ev[2] | (~consume & rotate);
    end
  assign any_pending = left | right | rotate;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus, cycle-by-cycle compare against a window-rule behavioural model
module tb_input_conditioner;
  localparam int D = 4, DLY = 10, PER = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0, enable = 1'b1, consume = 1'b0;
  logic left, right, rotate, any_pending;
  int total = 0, bad = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .enable(enable), .consume(consume),
    .left(left), .right(right), .rotate(rotate), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0b exp=%0b", name, $time, got, exp);
    end
  endtask

  // Model: stable flips once the last D synchronised samples all differ from it;
  // repeats fire at DLY, DLY+PER, DLY+2*PER ... cycles after an enabled press.
  logic m_st[3], m_stq[3], m_act[3], m_l = 1'b0, m_r = 1'b0, m_o = 1'b0;
  int   m_p[3];
  int   cyc = 0;
  logic rq[3][$], sh[3][$];

  initial for (int b = 0; b < 3; b++) begin
    m_st[b] = 1'b0; m_stq[b] = 1'b0; m_act[b] = 1'b0; m_p[b] = 0;
  end

  always @(posedge clk) begin
    logic e[3];
    logic rawv[3];
    logic sy, flip;
    int t;
    rawv[0] = btn_left; rawv[1] = btn_right; rawv[2] = btn_rotate;
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        m_st[b] = 1'b0; m_stq[b] = 1'b0; m_act[b] = 1'b0;
        rq[b].delete(); sh[b].delete();
      end
      m_l = 1'b0; m_r = 1'b0; m_o = 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        t = cyc - m_p[b];
        e[b] = (m_st[b] && !m_stq[b]) ||
               (b < 2 && m_act[b] && enable && m_st[b] && (t == DLY || (t > DLY && (t - DLY) % PER == 0)));
      end
      if (!enable) begin
        m_l = 1'b0; m_r = 1'b0; m_o = 1'b0;
      end else begin
        if (e[0] && e[1]) begin m_l = 1'b0; m_r = 1'b0; end
        else if (e[0]) begin m_l = 1'b1; m_r = 1'b0; end
        else if (e[1]) begin m_l = 1'b0; m_r = 1'b1; end
        else if (consume) begin m_l = 1'b0; m_r = 1'b0; end
        m_o = e[2] ? 1'b1 : (consume ? 1'b0 : m_o);
      end
      for (int b = 0; b < 3; b++) begin
        if (!enable || !m_st[b]) m_act[b] = 1'b0;
        else if (m_st[b] && !m_stq[b]) begin m_act[b] = 1'b1; m_p[b] = cyc; end
        m_stq[b] = m_st[b];
        sy = (rq[b].size() >= 2) ? rq[b][rq[b].size()-2] : 1'b0;
        sh[b].push_back(sy);
        if (sh[b].size() > 8) void'(sh[b].pop_front());
        flip = sh[b].size() >= D;
        for (int j = 0; j < D && flip; j++)
          if (sh[b][sh[b].size()-1-j] == m_st[b]) flip = 1'b0;
        if (flip) m_st[b] = ~m_st[b];
        rq[b].push_back(rawv[b]);
        if (rq[b].size() > 8) void'(rq[b].pop_front());
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("left_vs_model", left, m_l);
    chk("right_vs_model", right, m_r);
    chk("rotate_vs_model", rotate, m_o);
    chk("any_vs_model", any_pending, m_l | m_r | m_o);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_all();
    consume = 1'b1; step(1); consume = 1'b0;
  endtask

  initial begin
    step(3);
    chk("reset_left", left, 1'b0);
    chk("reset_any", any_pending, 1'b0);
    reset_n = 1'b1;
    step(1);
    chk("first_after_reset_any", any_pending, 1'b0);
    // clean press
    btn_left = 1'b1;
    step(6); chk("press_edge6", left, 1'b0);
    step(1); chk("press_edge7", left, 1'b1); chk("press_any", any_pending, 1'b1);
    clear_all(); chk("consumed", left, 1'b0);
    step(8); chk("no_event_before_repeat", left, 1'b0);
    step(1); chk("first_repeat", left, 1'b1);
    btn_left = 1'b0; step(10); clear_all(); step(2);
    // bounce
    for (int k = 0; k < 3; k++) begin
      btn_rotate = 1'b1; step(2); btn_rotate = 1'b0; step(2);
    end
    btn_rotate = 1'b1;
    step(6); chk("bounce_edge6", rotate, 1'b0);
    step(1); chk("bounce_edge7", rotate, 1'b1);
    clear_all(); step(30); chk("rotate_no_repeat", rotate, 1'b0);
    btn_rotate = 1'b0; step(8);
    // auto-repeat with consume every cycle
    consume = 1'b1; btn_right = 1'b1;
    step(7); chk("rep_press", right, 1'b1);
    step(1); chk("rep_cleared", right, 1'b0);
    step(9); chk("rep_first", right, 1'b1);
    step(1); chk("rep_cleared2", right, 1'b0);
    step(2); chk("rep_second", right, 1'b1);
    step(20); btn_right = 1'b0; step(12);
    btn_right = 1'b1;
    step(7); chk("repress", right, 1'b1);
    step(9); chk("repress_gap", right, 1'b0);
    step(1); chk("repress_first_repeat", right, 1'b1);
    btn_right = 1'b0; step(12); consume = 1'b0; step(2);
    // exclusion, rotate pending throughout
    btn_rotate = 1'b1; step(8); btn_rotate = 1'b0;
    btn_left = 1'b1; step(2); btn_right = 1'b1;
    step(5); chk("excl_left", left, 1'b1); chk("excl_right0", right, 1'b0);
    step(2); chk("excl_left0", left, 1'b0); chk("excl_right", right, 1'b1);
    chk("excl_rotate", rotate, 1'b1);
    btn_left = 1'b0; btn_right = 1'b0; step(20); clear_all(); step(2);
    btn_left = 1'b1; btn_right = 1'b1; btn_rotate = 1'b1;
    step(7); chk("cancel_left", left, 1'b0); chk("cancel_right", right, 1'b0);
    chk("cancel_rotate", rotate, 1'b1);
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0; step(25); clear_all(); step(2);
    // set beats consume
    btn_rotate = 1'b1; step(6); consume = 1'b1; step(1); consume = 1'b0;
    chk("set_beats_consume", rotate, 1'b1);
    btn_rotate = 1'b0; step(8); clear_all(); step(2);
    // enable and reset
    btn_left = 1'b1;
    step(7); chk("en_pending", left, 1'b1);
    enable = 1'b0; step(1); chk("en_cleared", left, 1'b0);
    step(15); chk("en_held_off", left, 1'b0);
    enable = 1'b1; step(15); chk("en_back_no_event", left, 1'b0);
    reset_n = 1'b0; step(1); chk("midhold_reset", any_pending, 1'b0);
    reset_n = 1'b1;
    step(6); chk("post_reset_edge6", left, 1'b0);
    step(1); chk("post_reset_edge7", left, 1'b1);
    btn_left = 1'b0; step(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Upstream stage of the game controller. It synchronises and debounces the three raw player buttons (left, right, rotate) and turns each press into a latched move request. Requests are held until the controller signals it has sampled them, which it does once per fall tick in its move-evaluation state. Left/right get auto-repeat while held; rotate fires once per press.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must hold a new level before it is accepted (20 ms at 50 MHz)
REPEAT_DELAY, 15000000, cycles from press event to first auto-repeat event (left/right only)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat events
CNT_W, 24, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
btn_left  input  1  raw asynchronous button, active-high (pressed = 1)
btn_right  input  1  raw asynchronous button, active-high
btn_rotate  input  1  raw asynchronous button, active-high
enable  input  1  1 = accept events; 0 = clear and suppress all requests (board clear)
consume  input  1  one-cycle pulse: controller has sampled requests
left  output  1  pending left-move request (level)
right  output  1  pending right-move request (level)
rotate  output  1  pending rotate request (level)
any_pending  output  1  OR of left/right/rotate

Behaviour:
- Reset is synchronous on clk; reset_n=0 clears all synchronisers, stable levels, counters and pending flags. All outputs are 0 during reset and on the first cycle after it.
- Per button: a 2-flop synchroniser, then a debouncer. When sync differs from stable, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1, stable takes sync and the counter clears. Whenever sync equals stable, the counter clears. Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- A press event is a one-cycle pulse on a stable 0->1 transition, detected against a registered copy of stable. A release generates no event.
- Latency: if raw goes high and stays high, counting the first edge that samples it high as edge 1, the pending output is 1 after edge DEBOUNCE_CYCLES+3.
- Auto-repeat, left/right only, counted from the press event while stable stays 1:
  - The first repeat event occurs REPEAT_DELAY cycles after the press event.
  - Further repeat events occur every REPEAT_PERIOD cycles after that.
  - Stable going 0 clears the repeat counter and phase immediately.
  - Rotate never repeats.
- Each button has a two-state repeat FSM: IDLE and HELD.
  - IDLE->HELD on press event.
  - HELD->IDLE on stable=0 or enable=0.
  - In HELD, a phase bit selects DELAY or PERIOD as the terminal count.
- Pending flags are updated every cycle with this priority:
  1. enable=0: all flags cleared; events ignored; repeat FSMs forced to IDLE.
  2. New event (press or repeat) on a button: that flag is set. Set beats consume in the same cycle, so a new request is never lost.
  3. consume=1 with no new event on that button: the flag is cleared. consume clears all three flags, not only the one the controller acted on.
- Left/right are mutually exclusive, latest wins:
  - A left event clears pending right, and vice versa.
  - Left and right events in the same cycle clear both flags (cancel).
  - Rotate is independent of left/right.
- Multiple events on one button before consume collapse into a single pending flag; there is no count.
- any_pending is combinational OR of the three registered flags.
- A button held through reset produces a press event once debounced after reset. Stable restarts at 0, so no release is required.
- Reset asserted mid-debounce or mid-repeat: everything returns to its reset value on that edge; no event is generated on the edge that asserts reset.

Test Plan:
(DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless noted)
- Clean press: btn_left 0->1 held, consume=0 -> left=1 after edge 7 and stays 1; any_pending=1. Pulse consume once -> left=0 the next cycle; no further event while held until the repeat at +10.
- Bounce: btn_rotate toggles every 2 cycles for 12 cycles, then held high -> no event during the toggling; exactly one rotate rise, 7 edges after the final rising transition; no repeat ever.
- Auto-repeat: hold btn_right 40 cycles, consume pulsed every cycle -> right set on press, then at +10, +13, +16, ... cycles from the press event. Release -> events stop; re-press restarts with delay 10.
- Exclusion: left event, then a right event 2 cycles later with no consume -> left=0, right=1. Left and right events in the same cycle -> both 0. Rotate pending throughout is unaffected.
- Set vs consume: consume pulsed in the same cycle as a rotate press event -> rotate stays 1 afterwards.
- enable/reset: enable=0 while left pending and button held -> left=0, and stays 0 while enable=0 despite the hold. Reset_n=0 for 1 cycle mid-hold -> all outputs 0; after release of reset a new press event appears 7 edges later.
